dsm_sequencer: RTL and testbench

Sequencing controller for the fractional-N divider path. It accepts a frequency word (integer modulus plus fractional alpha) over a valid/ready handshake and drives the first-order digital delta-sigma modulator's alpha, enable and clear. Once per divider cycle it combines the modulator MSB with the integer part to form the next multi-modulus divider modulus. Frequency changes are ramped in bounded steps, one step per divider cycle, to limit phase hits in the loop.

---
 rtl/dsm_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_dsm_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dsm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dsm_sequencer
// Purpose  : Sequencing controller for the fractional-N divider path.
//            Accepts an {n_int, alpha} frequency word over valid/ready and
//            drives the first-order DSM (alpha, enable, clear). It also forms
//            the multi-modulus divider modulus once per divider cycle.
//            Frequency changes are applied on divider ticks, either in
//            bounded steps or as one full jump.
// Options  : DSM_SEQ_RAMP_EN - when defined, cur walks toward tgt by at most
//            RAMP_STEP per div_tick. When undefined, the full change is
//            applied on the first div_tick after acceptance.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            enable_i        - 1 requests modulation, 0 parks in OFF
//            cfg_valid_i/cfg_ready_o/cfg_word_i - frequency word handshake
//            cfg_err_o       - pulse: accepted word had n_int < N_MIN
//            div_tick_i      - end-of-division pulse from the divider
//            dsm_msb_i       - DSM output bit for the current division
//            dsm_alpha_o/dsm_en_o/dsm_clr_o - DSM controls
//            div_mod_o/div_load_o - next modulus and its load strobe
//            settled_o       - applied word equals requested word
// Revision : 1.0 - initial release
// ============================================================================
module dsm_sequencer #(
  parameter int                        INT_W     = 8,
  parameter int                        FRAC_W    = 16,
  parameter logic [INT_W+FRAC_W-1:0]   RAMP_STEP = 24'h004000,
  parameter int                        N_MIN     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [INT_W+FRAC_W-1:0]   cfg_word_i,
  output logic                      cfg_err_o,
  input  logic                      div_tick_i,
  input  logic                      dsm_msb_i,
  output logic [FRAC_W-1:0]         dsm_alpha_o,
  output logic                      dsm_en_o,
  output logic                      dsm_clr_o,
  output logic [INT_W:0]            div_mod_o,
  output logic                      div_load_o,
  output logic                      settled_o
);

  localparam int W = INT_W + FRAC_W;

  localparam logic [1:0] S_OFF   = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_RAMP  = 2'd3;

  localparam logic [INT_W-1:0] N_MIN_INT = INT_W'(N_MIN);
  localparam logic [W-1:0]     RST_WORD  = {N_MIN_INT, {FRAC_W{1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     cur_q, cur_d;
  logic [W-1:0]     tgt_q, tgt_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [INT_W:0]   div_mod_q, div_mod_d;
  logic             div_load_q, div_load_d;

  logic             accept;
  logic             word_legal;
  logic             msb_used;
  logic [W-1:0]     ramp_next;

  assign accept     = cfg_valid_i & ready_q;
  assign word_legal = (cfg_word_i[W-1:FRAC_W] >= N_MIN_INT);

  // The DSM is only running (and its MSB meaningful) in RUN and RAMP; in
  // OFF and START the modulus is the bare integer part.
  assign msb_used = dsm_msb_i & ((state_q == S_RUN) | (state_q == S_RAMP));

`ifdef DSM_SEQ_RAMP_EN
  logic         tgt_above;
  logic [W-1:0] dist;
  logic [W-1:0] step;

  // Unsigned distance to the target, clipped to RAMP_STEP, applied in the
  // direction of the target.
  assign tgt_above = (tgt_q >= cur_q);
  assign dist      = tgt_above ? (tgt_q - cur_q) : (cur_q - tgt_q);
  assign step      = (dist > RAMP_STEP) ? RAMP_STEP : dist;
  assign ramp_next = tgt_above ? (cur_q + step) : (cur_q - step);
`else
  logic unused_ramp_step;

  assign ramp_next        = tgt_q;
  assign unused_ramp_step = ^RAMP_STEP;
`endif

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    tgt_d      = tgt_q;
    err_d      = accept & ~word_legal;
    div_load_d = div_tick_i;
    div_mod_d  = div_mod_q;

    // Modulus always uses cur as it stood before this tick's update.
    if (div_tick_i) begin
      div_mod_d = {1'b0, cur_q[W-1:FRAC_W]} + (INT_W+1)'(msb_used);
    end

    case (state_q)
      S_OFF: begin
        if (accept && word_legal) begin
          cur_d = cfg_word_i;
          tgt_d = cfg_word_i;
        end
        if (enable_i) begin
          state_d = S_START;
        end
      end
      S_START: begin
        cur_d   = tgt_q;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (accept && word_legal && (cfg_word_i != cur_q)) begin
          tgt_d   = cfg_word_i;
          state_d = S_RAMP;
        end
      end
      S_RAMP: begin
        if (div_tick_i) begin
          cur_d = ramp_next;
          if (ramp_next == tgt_q) begin
            state_d = S_RUN;
          end
        end
      end
      default: begin
        state_d = S_OFF;
      end
    endcase

    if (!enable_i) begin
      state_d = S_OFF;
    end

    // Registered so that ready lines up with the state it belongs to and
    // stays low while rst is held.
    ready_d = (state_d == S_OFF) || (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_OFF;
      cur_q      <= RST_WORD;
      tgt_q      <= RST_WORD;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      div_mod_q  <= {1'b0, N_MIN_INT};
      div_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      tgt_q      <= tgt_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      div_mod_q  <= div_mod_d;
      div_load_q <= div_load_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign cfg_err_o   = err_q;
  assign dsm_alpha_o = cur_q[FRAC_W-1:0];
  assign dsm_en_o    = (state_q == S_RUN) || (state_q == S_RAMP);
  assign dsm_clr_o   = (state_q == S_START);
  assign div_mod_o   = div_mod_q;
  assign div_load_o  = div_load_q;
  assign settled_o   = (state_q == S_RUN) && (cur_q == tgt_q);

endmodule
`default_nettype wire

// File: tb/tb_dsm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsm_sequencer
// Purpose  : Self-checking bench for dsm_sequencer. A vector table drives
//            one cycle per record and checks all outputs after the edge;
//            hand sequences cover same-cycle accept/tick, dropping enable
//            mid-change, reset mid-RAMP and modulus boundaries.
//            Expected values follow DSM_SEQ_RAMP_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [23:0] cfg_word;
  logic        cfg_err;
  logic        div_tick;
  logic        dsm_msb;
  logic [15:0] dsm_alpha;
  logic        dsm_en;
  logic        dsm_clr;
  logic [8:0]  div_mod;
  logic        div_load;
  logic        settled;

  int n_checks = 0;
  int n_fail   = 0;

  dsm_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_word_i  (cfg_word),
    .cfg_err_o   (cfg_err),
    .div_tick_i  (div_tick),
    .dsm_msb_i   (dsm_msb),
    .dsm_alpha_o (dsm_alpha),
    .dsm_en_o    (dsm_en),
    .dsm_clr_o   (dsm_clr),
    .div_mod_o   (div_mod),
    .div_load_o  (div_load),
    .settled_o   (settled)
  );

  always #5 clk = ~clk;

  // Output bundle: {ready, err, en, clr, load, settled, div_mod[8:0], alpha[15:0]}
  typedef struct {
    logic        en;
    logic        vld;
    logic [23:0] word;
    logic        tick;
    logic        msb;
    logic [30:0] exp;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  function automatic logic [30:0] ex(input logic rdy, input logic err,
                                     input logic en, input logic clr,
                                     input logic ld, input logic set,
                                     input int mod, input logic [15:0] al);
    return {rdy, err, en, clr, ld, set, 9'(mod), al};
  endfunction

  function automatic vec_t mk(input logic en, input logic vld,
                              input logic [23:0] word, input logic tick,
                              input logic msb, input logic [30:0] e);
    vec_t v;
    v.en = en; v.vld = vld; v.word = word; v.tick = tick; v.msb = msb;
    v.exp = e;
    return v;
  endfunction

  // Drive one cycle of inputs at a negedge and move to the next negedge.
  task automatic apply(input logic en, input logic vld, input logic [23:0] w,
                       input logic tk, input logic ms);
    enable    = en;
    cfg_valid = vld;
    cfg_word  = w;
    div_tick  = tk;
    dsm_msb   = ms;
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [30:0] e);
    logic [30:0] got;
    got = {cfg_ready, cfg_err, dsm_en, dsm_clr, div_load, settled, div_mod, dsm_alpha};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s: got rdy/err/en/clr/ld/set=%b mod=%0d alpha=%h, expected rdy/err/en/clr/ld/set=%b mod=%0d alpha=%h",
               name, got[30:25], got[24:16], got[15:0], e[30:25], e[24:16], e[15:0]);
    end
  endtask

  initial begin
    // ---- vector table -----------------------------------------------------
    vecs[0]  = mk(0, 0, 24'h0,      0, 0, ex(1,0,0,0,0,0, 4, 16'h0000)); // ready after reset
    vecs[1]  = mk(1, 0, 24'h0,      0, 0, ex(0,0,0,1,0,0, 4, 16'h0000)); // START, clr
    vecs[2]  = mk(1, 0, 24'h0,      1, 1, ex(1,0,1,0,1,1, 4, 16'h0000)); // tick in START: msb ignored
    vecs[3]  = mk(1, 0, 24'h0,      0, 0, ex(1,0,1,0,0,1, 4, 16'h0000));
    vecs[4]  = mk(0, 0, 24'h0,      0, 0, ex(1,0,0,0,0,0, 4, 16'h0000)); // back to OFF
    vecs[5]  = mk(0, 1, 24'h108000, 0, 0, ex(1,0,0,0,0,0, 4, 16'h8000)); // OFF load
    vecs[6]  = mk(0, 0, 24'h0,      1, 1, ex(1,0,0,0,1,0,16, 16'h8000)); // OFF tick, msb ignored
    vecs[7]  = mk(1, 0, 24'h0,      0, 0, ex(0,0,0,1,0,0,16, 16'h8000));
    vecs[8]  = mk(1, 0, 24'h0,      0, 0, ex(1,0,1,0,0,1,16, 16'h8000));
    for (int k = 0; k < 8; k++) begin
      vecs[9+k] = mk(1, 0, 24'h0, 1, logic'(k % 2),
                     ex(1,0,1,0,1,1, 16 + (k % 2), 16'h8000));
    end
    vecs[17] = mk(1, 0, 24'h0,      0, 0, ex(1,0,1,0,0,1,17, 16'h8000));
    vecs[18] = mk(1, 1, 24'h030000, 0, 0, ex(1,1,1,0,0,1,17, 16'h8000)); // illegal word
    vecs[19] = mk(1, 0, 24'h0,      0, 0, ex(1,0,1,0,0,1,17, 16'h8000));
    vecs[20] = mk(1, 1, 24'h108000, 0, 0, ex(1,0,1,0,0,1,17, 16'h8000)); // equal word: no-op
    vecs[21] = mk(1, 1, 24'h110000, 0, 0, ex(0,0,1,0,0,0,17, 16'h8000)); // -> RAMP
`ifdef DSM_SEQ_RAMP_EN
    vecs[22] = mk(1, 1, 24'h050000, 1, 0, ex(0,0,1,0,1,0,16, 16'hC000)); // step to 0x10C000
    vecs[23] = mk(1, 0, 24'h0,      0, 0, ex(0,0,1,0,0,0,16, 16'hC000));
    vecs[24] = mk(1, 0, 24'h0,      1, 1, ex(1,0,1,0,1,1,17, 16'h0000)); // reaches 0x110000
    vecs[25] = mk(1, 0, 24'h0,      0, 0, ex(1,0,1,0,0,1,17, 16'h0000));
`else
    vecs[22] = mk(1, 1, 24'h050000, 1, 0, ex(1,0,1,0,1,1,16, 16'h0000)); // full jump
    vecs[23] = mk(1, 0, 24'h0,      0, 0, ex(1,0,1,0,0,1,16, 16'h0000));
    vecs[24] = mk(1, 0, 24'h0,      1, 1, ex(1,0,1,0,1,1,18, 16'h0000));
    vecs[25] = mk(1, 0, 24'h0,      0, 0, ex(1,0,1,0,0,1,18, 16'h0000));
`endif

    // ---- reset --------------------------------------------------------------
    rst = 1'b1;
    enable = 1'b0; cfg_valid = 1'b0; cfg_word = 24'h0; div_tick = 1'b0; dsm_msb = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", ex(0,0,0,0,0,0, 4, 16'h0000));
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].en, vecs[i].vld, vecs[i].word, vecs[i].tick, vecs[i].msb);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ---- same-cycle accept and tick in RUN (cur = 0x110000) ---------------
    apply(1, 1, 24'h118000, 1, 0);
    check("acc_tick_oldmod", ex(0,0,1,0,1,0,17, 16'h0000));
    apply(1, 0, 24'h0, 1, 0);
`ifdef DSM_SEQ_RAMP_EN
    check("acc_tick_step1", ex(0,0,1,0,1,0,17, 16'h4000));
`else
    check("acc_tick_step1", ex(1,0,1,0,1,1,17, 16'h8000));
`endif
    apply(1, 0, 24'h0, 1, 0);
    check("acc_tick_done", ex(1,0,1,0,1,1,17, 16'h8000));

    // ---- drop enable while changing, then re-enable -----------------------
    apply(1, 1, 24'h200000, 0, 0);
    check("drop_ramp", ex(0,0,1,0,0,0,17, 16'h8000));
    apply(0, 0, 24'h0, 0, 0);
    check("drop_off", ex(1,0,0,0,0,0,17, 16'h8000));
    apply(1, 0, 24'h0, 0, 0);
    check("reen_start", ex(0,0,0,1,0,0,17, 16'h8000));
    apply(1, 0, 24'h0, 0, 0);
    check("reen_run", ex(1,0,1,0,0,1,17, 16'h0000));
    apply(1, 0, 24'h0, 1, 0);
    check("reen_tick", ex(1,0,1,0,1,1,32, 16'h0000));

    // ---- reset mid-RAMP -----------------------------------------------------
    apply(1, 1, 24'h300000, 0, 0);
    check("rst_pre_ramp", ex(0,0,1,0,0,0,32, 16'h0000));
    rst = 1'b1;
    apply(1, 0, 24'h0, 1, 1);
    check("rst_mid_ramp", ex(0,0,0,0,0,0, 4, 16'h0000));
    rst = 1'b0;
    apply(0, 0, 24'h0, 0, 0);
    check("rst_release", ex(1,0,0,0,0,0, 4, 16'h0000));

    // ---- n_int boundaries and modulus without wrap --------------------------
    apply(0, 1, 24'h04ABCD, 0, 0);
    check("nmin_legal", ex(1,0,0,0,0,0, 4, 16'hABCD));
    apply(0, 1, 24'h03FFFF, 0, 0);
    check("nmin_illegal", ex(1,1,0,0,0,0, 4, 16'hABCD));
    apply(0, 1, 24'hFF1234, 0, 0);
    check("max_load", ex(1,0,0,0,0,0, 4, 16'h1234));
    apply(1, 0, 24'h0, 0, 0);
    check("max_start", ex(0,0,0,1,0,0, 4, 16'h1234));
    apply(1, 0, 24'h0, 0, 0);
    check("max_run", ex(1,0,1,0,0,1, 4, 16'h1234));
    apply(1, 0, 24'h0, 1, 1);
    check("max_mod_nowrap", ex(1,0,1,0,1,1,256, 16'h1234));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
